// File: rtl/instr_fetcher.sv
// Instruction byte fetcher: reads opcode/operand bytes from memory until the external
// decoder reports a complete instruction. Optional next_pc output: INSTR_FETCHER_NEXT_PC_EN.
module instr_fetcher #(
  parameter logic [7:0] INSN_GROUP_NEED_MORE_BYTES = 8'hFF,
  parameter logic [7:0] INSN_GROUP_ILLEGAL_INSTR   = 8'hFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_valid,
  output logic [31:0] dec_instr,
  output logic [1:0]  dec_op_len,
  input  logic [2:0]  dec_len,
  input  logic [7:0]  dec_group,
`ifdef INSTR_FETCHER_NEXT_PC_EN
  output logic [15:0] next_pc,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] instr,
  output logic [2:0]  instr_len,
  output logic [7:0]  group
);

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned MAX_BYTES = 4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CHECK, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [INSTR_W-1:0]  r_buf;
  logic [CNT_W-1:0]    r_count;
  logic [1:0]          r_op_len;
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_busy;
  logic                r_done;
  logic [INSTR_W-1:0]  r_instr;
  logic [CNT_W-1:0]    r_instr_len;
  logic [7:0]          r_group;
  logic [ADDR_W-1:0]   r_next_pc;

  logic                w_need_more;
  logic                w_illegal;
  logic                w_want_byte;
  logic                w_go_done;
  logic [ADDR_W-1:0]   w_fetch_addr;

  // Decision for the CHECK state; an opcode still incomplete after two bytes is illegal.
  assign w_need_more  = (dec_group == INSN_GROUP_NEED_MORE_BYTES);
  assign w_illegal    = w_need_more && (r_op_len == 2'd2);
  assign w_want_byte  = (r_count < dec_len) && (r_count < CNT_W'(MAX_BYTES));
  assign w_go_done    = w_illegal || (!w_need_more && !w_want_byte);
  assign w_fetch_addr = r_base + ADDR_W'(r_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_buf       <= '0;
      r_count     <= '0;
      r_op_len    <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_instr     <= '0;
      r_instr_len <= '0;
      r_group     <= '0;
      r_next_pc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base     <= pc;
            r_buf      <= '0;
            r_count    <= '0;
            r_op_len   <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= pc;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_valid) begin
            r_buf[{r_count[1:0], 3'b000} +: 8] <= mem_data;
            r_count  <= r_count + CNT_W'(1);
            r_mem_rd <= 1'b0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_go_done) begin
            r_instr     <= r_buf;
            r_instr_len <= r_count;
            r_group     <= w_illegal ? INSN_GROUP_ILLEGAL_INSTR : dec_group;
            r_next_pc   <= w_fetch_addr;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_need_more && (CNT_W'(r_op_len) < r_count)) begin
            r_op_len <= r_op_len + 2'd1;
          end else begin
            // Either the decoder needs the next opcode byte or operands remain.
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_fetch_addr;
            r_state    <= S_FETCH;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign dec_instr  = r_buf;
  assign dec_op_len = r_op_len;
  assign busy       = r_busy;
  assign done       = r_done;
  assign instr      = r_instr;
  assign instr_len  = r_instr_len;
  assign group      = r_group;
`ifdef INSTR_FETCHER_NEXT_PC_EN
  assign next_pc    = r_next_pc;
`else
  logic w_unused_next_pc;
  assign w_unused_next_pc = ^r_next_pc;
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher with a small memory and decoder model.
// Honours INSTR_FETCHER_NEXT_PC_EN for the optional next_pc checks.
module tb_instr_fetcher;

  localparam logic [7:0] G_NEED  = 8'hFF;
  localparam logic [7:0] G_ILL   = 8'hFE;
  localparam logic [7:0] G_NOP   = 8'h01;
  localparam logic [7:0] G_DDNN  = 8'h02;
  localparam logic [7:0] G_REGN  = 8'h03;
  localparam logic [7:0] G_IDXN  = 8'h04;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [31:0] dec_instr;
  logic [1:0]  dec_op_len;
  logic [2:0]  dec_len;
  logic [7:0]  dec_group;
  logic        busy;
  logic        done;
  logic [31:0] instr;
  logic [2:0]  instr_len;
  logic [7:0]  group;
`ifdef INSTR_FETCHER_NEXT_PC_EN
  logic [15:0] next_pc;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        hold_off = 1'b0;
  logic [15:0] q_addr[$];
  logic [1:0]  q_op[$];
  int          done_seen = 0;
  logic        prev_pending = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  instr_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .dec_instr(dec_instr), .dec_op_len(dec_op_len), .dec_len(dec_len), .dec_group(dec_group),
`ifdef INSTR_FETCHER_NEXT_PC_EN
    .next_pc(next_pc),
`endif
    .busy(busy), .done(done), .instr(instr), .instr_len(instr_len), .group(group)
  );

  always #5 clk = ~clk;

  // Memory with a programmable number of wait states per read.
  assign mem_data  = mem[mem_addr];
  assign mem_valid = mem_rd && !hold_off && (wcnt == wait_cfg);
  always @(posedge clk) wcnt <= (mem_rd && !mem_valid) ? wcnt + 1 : 0;

  // Decoder model: {group, total length} from the known opcode bytes.
  function automatic logic [10:0] decode(input logic [31:0] b, input logic [1:0] ol);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = b[7:0];
    b1 = b[15:8];
    if (ol == 2'd0) return {G_NEED, 3'd0};
    if (ol == 2'd1) begin
      case (b0)
        8'h00: return {G_NOP, 3'd1};
        8'h01: return {G_DDNN, 3'd3};
        8'h3E: return {G_REGN, 3'd2};
        8'hDD, 8'hED: return {G_NEED, 3'd0};
        default: return {G_NOP, 3'd1};
      endcase
    end
    if (b0 == 8'hDD && b1 == 8'h36) return {G_IDXN, 3'd4};
    return {G_NEED, 3'd0};
  endfunction

  always_comb {dec_group, dec_len} = decode(dec_instr, dec_op_len);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observation at the falling edge: read addresses, op_len history, done pulses, address stability.
  always @(negedge clk) begin
    if (mem_rd && mem_valid) q_addr.push_back(mem_addr);
    if (busy && (q_op.size() == 0 || q_op[$] != dec_op_len)) q_op.push_back(dec_op_len);
    if (done) done_seen++;
    if (mem_rd && prev_pending) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
    prev_pending = mem_rd && !mem_valid;
    prev_addr    = mem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [15:0] a, input int waits, input bit extra,
                     input logic [31:0] e_instr, input logic [2:0] e_len, input logic [7:0] e_grp,
                     input logic [15:0] e_npc);
    logic [15:0] ea;
    int n;
    q_addr.delete();
    q_op.delete();
    wait_cfg = waits;
    pc = a;
    start = 1'b1;
    step();
    if (extra) begin
      pc = 16'h0300;
      step();
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_instr"}, instr, e_instr);
    chk({tag, "_len"}, 32'(instr_len), 32'(e_len));
    chk({tag, "_group"}, 32'(group), 32'(e_grp));
    chk({tag, "_nreads"}, q_addr.size(), 32'(e_len));
    for (int i = 0; i < q_addr.size(); i++) begin
      ea = a + 16'(i);
      chk({tag, "_addr"}, 32'(q_addr[i]), 32'(ea));
    end
`ifdef INSTR_FETCHER_NEXT_PC_EN
    chk({tag, "_next_pc"}, 32'(next_pc), 32'(e_npc));
`else
    if (e_npc == 16'hxxxx) $display("unexpected");
`endif
    step();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, instr, e_instr);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'h01; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    mem[16'h0300] = 8'hDD; mem[16'h0301] = 8'h36; mem[16'h0302] = 8'h05; mem[16'h0303] = 8'hAA;
    mem[16'h0400] = 8'hED; mem[16'h0401] = 8'h00;
    mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h7F;

    // Reset, with start asserted at the same time.
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_len", 32'(instr_len), 32'd0);
    chk("rst_group", 32'(group), 32'd0);
    chk("rst_op_len", 32'(dec_op_len), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    step();

    // Cycle-exact single-byte NOP at 0x0100.
    pc = 16'h0100;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_mem_rd", 32'(mem_rd), 32'd1);
    chk("c1_mem_addr", 32'(mem_addr), 32'h0100);
    step();
    chk("c2_mem_rd", 32'(mem_rd), 32'd0);
    chk("c2_busy", 32'(busy), 32'd1);
    chk("c2_op_len", 32'(dec_op_len), 32'd0);
    chk("c2_done", 32'(done), 32'd0);
    step();
    chk("c3_op_len", 32'(dec_op_len), 32'd1);
    chk("c3_done", 32'(done), 32'd0);
    step();
    chk("c4_done", 32'(done), 32'd1);
    chk("c4_busy", 32'(busy), 32'd0);
    chk("c4_instr", instr, 32'h0);
    chk("c4_len", 32'(instr_len), 32'd1);
    chk("c4_group", 32'(group), 32'(G_NOP));
    step();
    chk("c5_done", 32'(done), 32'd0);

    // Three-byte load; a second start during the fetch must be ignored.
    run("ld_dd_nn", 16'h0200, 0, 1'b1, 32'h0012_3401, 3'd3, G_DDNN, 16'h0203);

    // Four-byte indexed load with two wait states per read.
    run("ld_idx", 16'h0300, 2, 1'b0, 32'hAA05_36DD, 3'd4, G_IDXN, 16'h0304);
    chk("op_seq_n", q_op.size(), 32'd3);
    for (int i = 0; i < q_op.size(); i++) chk("op_seq", 32'(q_op[i]), 32'(i));

    // Undefined ED-prefixed opcode.
    run("illegal", 16'h0400, 1, 1'b0, 32'h0000_00ED, 3'd2, G_ILL, 16'h0402);

    // Address wrap from 0xFFFF to 0x0000.
    run("wrap", 16'hFFFF, 0, 1'b0, 32'h0000_7F3E, 3'd2, G_REGN, 16'h0001);

    // Reset while a read is pending.
    hold_off = 1'b1;
    wait_cfg = 0;
    pc = 16'h0100;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rf_pending_rd", 32'(mem_rd), 32'd1);
    done_seen = 0;
    reset = 1'b1;
    step();
    chk("rf_mem_rd", 32'(mem_rd), 32'd0);
    chk("rf_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    hold_off = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rf_no_done", done_seen, 32'd0);
    run("after_rst", 16'h0100, 0, 1'b0, 32'h0, 3'd1, G_NOP, 16'h0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
